// File: rtl/rd_burst_ctrl.sv
// rd_burst_ctrl
// Splits one line-read request into AXI4 INCR read bursts of at most
// MAX_BURST beats and returns the data beat-by-beat to the requester.
// Addresses are in DQ-word units. One 256-bit beat covers 8 DQ words, so
// consecutive bursts advance the address by beats*8.
//
// Ports:
//   ddr_clk, ddr_rstn         clock, async active-low reset
//   ddr_rreq/raddr/rd_len     line read request (taken only while ddr_rrdy=1)
//   ddr_rrdy                  idle, request can be accepted
//   ddr_rdone                 one-cycle completion pulse
//   ddr_rdata/ddr_rdata_en    returned beat (registered copy of the R channel)
//   axi_ar*                   AXI read address channel
//   axi_r*                    AXI read data channel
//   rd_err                    sticky protocol error flag
//
// Optional feature macro: RD_BURST_ERR_CHK_EN
//   defined   : rd_err flags an rlast/beat-count disagreement, or rvalid
//               arriving outside the data phase
//   undefined : rd_err is tied low and the check logic is absent
//
// state | meaning
// IDLE  | ready for a request
// ADDR  | AR presented, waiting for axi_arready
// DATA  | receiving the beats of the current burst
// DONE  | one-cycle completion pulse
module rd_burst_ctrl #(
    parameter int ADDR_WIDTH = 27,
    parameter int LEN_WIDTH  = 16,
    parameter int DQ_WIDTH   = 32,
    parameter int MAX_BURST  = 16
) (
    input  logic                  ddr_clk,
    input  logic                  ddr_rstn,
    input  logic                  ddr_rreq,
    input  logic [ADDR_WIDTH-1:0] ddr_raddr,
    input  logic [LEN_WIDTH-1:0]  ddr_rd_len,
    output logic                  ddr_rrdy,
    output logic                  ddr_rdone,
    output logic [8*DQ_WIDTH-1:0] ddr_rdata,
    output logic                  ddr_rdata_en,
    output logic [ADDR_WIDTH-1:0] axi_araddr,
    output logic [7:0]            axi_arlen,
    output logic                  axi_arvalid,
    input  logic                  axi_arready,
    input  logic [8*DQ_WIDTH-1:0] axi_rdata,
    input  logic                  axi_rvalid,
    input  logic                  axi_rlast,
    output logic                  axi_rready,
    output logic                  rd_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
    logic [LEN_WIDTH-1:0]  remain_q, remain_d;
    logic [8:0]            burst_beats_q, burst_beats_d;
    logic [8:0]            beat_cnt_q, beat_cnt_d;
    logic [7:0]            arlen_q, arlen_d;
    logic [8*DQ_WIDTH-1:0] rdata_q, rdata_d;
    logic                  rdata_en_q, rdata_en_d;

    logic                  r_hs;
    logic                  last_beat;
    logic [LEN_WIDTH-1:0]  remain_after;
    logic                  load_burst;
    logic [LEN_WIDTH-1:0]  load_len;
    logic [8:0]            next_beats;

    // Beats in the next burst: min(len, MAX_BURST). Only called with len > 0.
    function automatic logic [8:0] beats_for(input logic [LEN_WIDTH-1:0] len);
        if (len < LEN_WIDTH'(MAX_BURST))
            beats_for = len[8:0];
        else
            beats_for = 9'(MAX_BURST);
    endfunction

    always_comb begin
        state_d       = state_q;
        cur_addr_d    = cur_addr_q;
        remain_d      = remain_q;
        burst_beats_d = burst_beats_q;
        beat_cnt_d    = beat_cnt_q;
        arlen_d       = arlen_q;
        load_burst    = 1'b0;
        load_len      = ddr_rd_len;

        r_hs         = axi_rvalid && (state_q == ST_DATA);
        last_beat    = (beat_cnt_q == 9'd1);
        remain_after = remain_q - LEN_WIDTH'(burst_beats_q);

        case (state_q)
            ST_IDLE: begin
                if (ddr_rreq) begin
                    cur_addr_d = ddr_raddr;
                    remain_d   = ddr_rd_len;
                    if (ddr_rd_len == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d    = ST_ADDR;
                        load_burst = 1'b1;
                        load_len   = ddr_rd_len;
                    end
                end
            end
            ST_ADDR: begin
                if (axi_arready)
                    state_d = ST_DATA;
            end
            ST_DATA: begin
                if (r_hs) begin
                    beat_cnt_d = beat_cnt_q - 9'd1;
                    if (last_beat) begin
                        remain_d   = remain_after;
                        // Address wraps silently at 2^ADDR_WIDTH.
                        cur_addr_d = cur_addr_q + ADDR_WIDTH'({burst_beats_q, 3'b000});
                        if (remain_after != '0) begin
                            state_d    = ST_ADDR;
                            load_burst = 1'b1;
                            load_len   = remain_after;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Burst size is fixed on entry to ADDR so the AR stays stable.
        next_beats = beats_for(load_len);
        if (load_burst) begin
            burst_beats_d = next_beats;
            beat_cnt_d    = next_beats;
            arlen_d       = 8'(next_beats - 9'd1);
        end

        rdata_d    = axi_rdata;
        rdata_en_d = axi_rvalid && axi_rready;
    end

    always_ff @(posedge ddr_clk or negedge ddr_rstn) begin
        if (!ddr_rstn) begin
            state_q       <= ST_IDLE;
            cur_addr_q    <= '0;
            remain_q      <= '0;
            burst_beats_q <= '0;
            beat_cnt_q    <= '0;
            arlen_q       <= '0;
            rdata_q       <= '0;
            rdata_en_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cur_addr_q    <= cur_addr_d;
            remain_q      <= remain_d;
            burst_beats_q <= burst_beats_d;
            beat_cnt_q    <= beat_cnt_d;
            arlen_q       <= arlen_d;
            rdata_q       <= rdata_d;
            rdata_en_q    <= rdata_en_d;
        end
    end

    assign ddr_rrdy     = (state_q == ST_IDLE);
    assign ddr_rdone    = (state_q == ST_DONE);
    assign axi_arvalid  = (state_q == ST_ADDR);
    assign axi_rready   = (state_q == ST_DATA);
    assign axi_araddr   = cur_addr_q;
    assign axi_arlen    = arlen_q;
    assign ddr_rdata    = rdata_q;
    assign ddr_rdata_en = rdata_en_q;

`ifdef RD_BURST_ERR_CHK_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (r_hs && (axi_rlast != last_beat))
            err_d = 1'b1;
        if (axi_rvalid && (state_q != ST_DATA))
            err_d = 1'b1;
    end

    always_ff @(posedge ddr_clk or negedge ddr_rstn) begin
        if (!ddr_rstn)
            err_q <= 1'b0;
        else
            err_q <= err_d;
    end

    assign rd_err = err_q;
`else
    // rlast only feeds the error check; beat counting ends each burst.
    logic unused_rlast;
    assign unused_rlast = axi_rlast;
    assign rd_err       = 1'b0;
`endif

endmodule
